// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring radix-2 divider for DIV/DIVU
// Quotient goes to LO, remainder to HI; state advances on the falling edge of clk_in.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             neg_dvd;
    logic             neg_dvs;
    logic [WIDTH-1:0] dvd_raw;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH:0]   r_acc;

    logic             in_neg_dvd;
    logic             in_neg_dvs;
    logic [WIDTH-1:0] in_dvd_mag;
    logic [WIDTH-1:0] in_dvs_mag;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Signs only count for DIV; |0x80000000| wraps back to 0x80000000, which is
    // the correct unsigned magnitude.
    assign in_neg_dvd = is_signed & dividend[WIDTH-1];
    assign in_neg_dvs = is_signed & divisor[WIDTH-1];
    assign in_dvd_mag = in_neg_dvd ? -dividend : dividend;
    assign in_dvs_mag = in_neg_dvs ? -divisor : divisor;

    assign trial = {r_acc[WIDTH-1:0], q_sh[WIDTH-1]} - {1'b0, dvs_mag};
    assign q_fix = (neg_dvd ^ neg_dvs) ? -q_sh : q_sh;
    assign r_fix = neg_dvd ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

    always_ff @(negedge clk_in or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            count       <= '0;
            neg_dvd     <= 1'b0;
            neg_dvs     <= 1'b0;
            dvd_raw     <= '0;
            dvs_mag     <= '0;
            q_sh        <= '0;
            r_acc       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        neg_dvd <= in_neg_dvd;
                        neg_dvs <= in_neg_dvs;
                        dvd_raw <= dividend;
                        dvs_mag <= in_dvs_mag;
                        q_sh    <= in_dvd_mag;
                        r_acc   <= '0;
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!trial[WIDTH]) begin
                        r_acc <= trial;
                        q_sh  <= {q_sh[WIDTH-2:0], 1'b1};
                    end else begin
                        r_acc <= {r_acc[WIDTH-1:0], q_sh[WIDTH-1]};
                        q_sh  <= {q_sh[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // A zero divisor ran the full latency but its datapath result is meaningless.
                    if (dvs_mag == '0) begin
                        quotient    <= '1;
                        remainder   <= dvd_raw;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= q_fix;
                        remainder   <= r_fix;
                        div_by_zero <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - randomized self-checking bench for div_unit
module tb_div_unit;

    logic        clk_in;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit truncating division of the interpreted operands.
    task automatic model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
        longint x;
        longint y;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
            x = sgn ? longint'($signed(a)) : longint'({32'd0, a});
            y = sgn ? longint'($signed(b)) : longint'({32'd0, b});
            q = 32'(x / y);
            r = 32'(x % y);
            z = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Counts falling edges until done is seen; busy must stay high before that.
    task automatic wait_done(output int edges, output int busy_drops);
        edges = 0;
        busy_drops = 0;
        do begin
            @(negedge clk_in);
            @(posedge clk_in);
            edges++;
            if (!done && !busy) busy_drops++;
        end while (!done && edges < 100);
    endtask

    task automatic run_op(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        int          edges;
        int          drops;
        model(sgn, a, b, eq, er, ez);
        start = 1'b1;
        is_signed = sgn;
        dividend = a;
        divisor = b;
        @(negedge clk_in);
        @(posedge clk_in);
        start = 1'b0;
        is_signed = $urandom_range(0, 1);
        dividend = $urandom;
        divisor = $urandom;
        check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
        wait_done(edges, drops);
        check({tag, "_latency"}, edges, 32'd33);
        check({tag, "_busy_held"}, drops, 32'd0);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_quot"}, quotient, eq);
        check({tag, "_rem"}, remainder, er);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
        @(negedge clk_in);
        @(posedge clk_in);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int edges;
        int drops;
        int dones;
        reset = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        dividend = '0;
        divisor = '0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quot", quotient, 32'd0);
        check("rst_rem", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(posedge clk_in);
        @(posedge clk_in);
        reset = 1'b0;

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0);
        run_op("divu_9_3", 1'b0, 32'd9, 32'd3);
        run_op("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0);

        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), pick(), pick());
        end

        // Start conflict: restarts at edges 10 and 33 are ignored, edge 34 is taken.
        start = 1'b1;
        is_signed = 1'b0;
        dividend = 32'd100;
        divisor = 32'd7;
        @(negedge clk_in);
        @(posedge clk_in);
        for (int k = 1; k <= 33; k++) begin
            start = (k == 10 || k == 33);
            dividend = 32'd50;
            divisor = 32'd5;
            @(negedge clk_in);
            @(posedge clk_in);
        end
        check("conf_done33", {31'd0, done}, 32'd1);
        check("conf_quot", quotient, 32'd14);
        check("conf_rem", remainder, 32'd2);
        start = 1'b1;
        @(negedge clk_in);
        @(posedge clk_in);
        start = 1'b0;
        check("conf_done_fall", {31'd0, done}, 32'd0);
        check("conf_busy34", {31'd0, busy}, 32'd1);
        wait_done(edges, drops);
        check("conf_latency2", edges, 32'd33);
        check("conf_quot2", quotient, 32'd10);
        check("conf_rem2", remainder, 32'd0);

        // Reset between edges 10 and 11 of an operation.
        start = 1'b1;
        dividend = 32'd100;
        divisor = 32'd7;
        @(negedge clk_in);
        @(posedge clk_in);
        start = 1'b0;
        repeat (10) begin
            @(negedge clk_in);
            @(posedge clk_in);
        end
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_quot", quotient, 32'd0);
        check("mid_rst_rem", remainder, 32'd0);
        check("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(posedge clk_in);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk_in);
            @(posedge clk_in);
            if (done || busy) dones++;
        end
        check("mid_rst_no_done", dones, 32'd0);
        run_op("after_rst_20_6", 1'b0, 32'd20, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

- Multi-cycle 32-bit integer divider for DIV/DIVU, used by the Execute stage.
- Execute hands it a pair of operands. The divider asserts `busy` for a fixed number of cycles, and the pipeline stall logic uses `busy` to freeze IF/ID.
- When finished, it returns the quotient (destined for LO) and the remainder (destined for HI) with a one-cycle `done` pulse.
- It uses a restoring radix-2 algorithm on operand magnitudes, followed by a sign-correction step.

## Interface

Parameters:
- `WIDTH`, default 32: operand/result width. Only 32 is required to work.

Ports:
- `clk_in` in 1: pipeline clock. All state updates on its falling edge, like the pipeline registers.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request. Sampled on a falling edge while the unit is not busy.
- `is_signed` in 1: 1 = DIV (two's complement), 0 = DIVU. Latched with `start`.
- `dividend` in 32: latched with `start`.
- `divisor` in 32: latched with `start`.
- `busy` out 1: high while an operation is in flight. Drives the pipeline stall.
- `done` out 1: one-cycle pulse when `quotient`/`remainder` are valid.
- `quotient` out 32: result for LO. Holds its value until the next completion.
- `remainder` out 32: result for HI. Holds its value until the next completion.
- `div_by_zero` out 1: qualifies the current results. Updated with `done`.

## Operation

States and transitions:
- IDLE: `start` moves to RUN.
- RUN: stays for 32 iterations, then moves to FIX.
- FIX: moves to IDLE.
- The FIX→IDLE edge asserts `done`.

Start (IDLE and `start`=1):
- Latch `is_signed`.
- Latch the sign of the dividend and the sign of the divisor, taking MSBs only when signed.
- Latch magnitudes `|dividend|` and `|divisor|` as 32-bit unsigned values. |0x80000000| = 0x80000000.
- Clear the 33-bit partial remainder `R`.
- Load the quotient shift register with the dividend magnitude.
- Clear `count`.

RUN, one bit per cycle:
- Form the trial value `T = {R[31:0], Q[31]} - {1'b0, |divisor|}`, 33 bits wide.
- If `T` is non-negative: `R = T` and shift 1 into `Q`.
- Otherwise: `R = {R[31:0], Q[31]}` and shift 0 into `Q`.
- `count` is 5 bits and increments each iteration.
- After the iteration with `count`=31, go to FIX.

FIX:
- Quotient is negated when the operation is signed and the operand signs differ.
- Remainder is negated when the operation is signed and the dividend is negative.
- Results register into `quotient`/`remainder` and `done`=1.

Divisor = 0:
- Runs the full latency.
- Outputs are overridden: `quotient`=0xFFFFFFFF, `remainder`=original dividend (raw bits), `div_by_zero`=1.
- Otherwise `div_by_zero`=0.

Signed overflow (0x80000000 / -1):
- Falls out naturally: `quotient`=0x80000000, `remainder`=0.
- No flag is raised.

Other rules:
- `start` while `busy`=1 is ignored. The in-flight operation is unaffected.
- Inputs may change freely after the start edge.

## Timing

- Start accepted at falling edge N.
- `busy`=1 after edges N through N+32.
- Iterations occur on edges N+1 through N+32.
- FIX occurs on edge N+33: `done`=1 and results are valid during the cycle after edge N+33, and `busy`=0.
- Latency is 33 cycles from the start edge to `done`, independent of operand values.
- Back-to-back: `start` sampled at edge N+33 is not accepted, because the unit is still in FIX. The earliest accepted start is at edge N+34.
- `done` is exactly one cycle wide and falls at edge N+34 unless cleared earlier by reset.

Reset, asserted at any time (including mid-operation):
- Immediately: state=IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, `count`=0.
- The in-flight operation is discarded. No `done` is produced for it.
- The first start is accepted on the first falling edge after reset deasserts.

## Test plan

- DIVU 100 / 7: `start` at edge 0 → `busy` high for edges 0–32; `done` after edge 33 with `quotient`=14, `remainder`=2, `div_by_zero`=0.
- DIV -7 / 2 (0xFFFFFFF9, 0x2) → `quotient`=0xFFFFFFFD, `remainder`=0xFFFFFFFF. DIV 7 / -2 → `quotient`=0xFFFFFFFD, `remainder`=1.
- DIV 0x80000000 / 0xFFFFFFFF → `quotient`=0x80000000, `remainder`=0. DIVU of the same operands → `quotient`=0, `remainder`=0x80000000.
- DIVU 5 / 0 → after 33 cycles, `quotient`=0xFFFFFFFF, `remainder`=5, `div_by_zero`=1. Next DIVU 9 / 3 → `quotient`=3, `remainder`=0, `div_by_zero`=0.
- Start conflict: `start` with 100/7, then a second `start` (50/5) at edge 10 → ignored; result 14/2 at edge 33. Start 50/5 at edge 33 → ignored. Start 50/5 at edge 34 → `done` at edge 67 with `quotient`=10, `remainder`=0.
- Reset mid-operation: start 100/7, assert `reset` between edges 10 and 11 → `busy`=0 and all outputs 0 immediately; no `done` ever appears for 100/7. A fresh 20/6 after release → `quotient`=3, `remainder`=2 after 33 cycles.
